// File: rtl/mmio_bus_pkg.sv
// Shared types and helpers for the MMIO bus decoder and its region matcher.
package mmio_bus_pkg;

    localparam int MAX_SLV = 16;
    localparam int MAX_W   = 32;
    localparam int IDX_W   = 4;

    typedef logic [IDX_W-1:0] slv_idx_t;

    // Index reported when no region claims the address; only meaningful with hit=0.
    localparam slv_idx_t IDX_NONE = '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Extract field idx (w bits wide) from a packed per-slave parameter vector.
    function automatic logic [MAX_W-1:0] field_of(input logic [MAX_SLV*MAX_W-1:0] vec,
                                                  input int idx, input int w);
        return MAX_W'(vec >> (idx * w));
    endfunction

    function automatic slv_idx_t to_idx(input int i);
        return slv_idx_t'(i);
    endfunction

endpackage

// File: rtl/mmio_region_match.sv
// Combinational address decode: instruction fetches go to the default slave,
// data accesses take the lowest-numbered matching region, then the default
// slave if enabled.
module mmio_region_match
    import mmio_bus_pkg::*;
#(
    parameter int                      ADDR_W   = 16,
    parameter int                      N_SLV    = 4,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = '0,
    parameter int                      DEF_SLV  = N_SLV - 1,
    parameter bit                      DEF_EN   = 1'b1
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              instr_i,
    output logic              hit_o,
    output slv_idx_t          idx_o
);

    localparam logic [MAX_SLV*MAX_W-1:0] BASE_EXT = (MAX_SLV*MAX_W)'(SLV_BASE);
    localparam logic [MAX_SLV*MAX_W-1:0] MASK_EXT = (MAX_SLV*MAX_W)'(SLV_MASK);

    logic [N_SLV-1:0] match;

    for (genvar g = 0; g < N_SLV; g++) begin : g_region
        localparam logic [ADDR_W-1:0] BASE = ADDR_W'(field_of(BASE_EXT, g, ADDR_W));
        localparam logic [ADDR_W-1:0] MASK = ADDR_W'(field_of(MASK_EXT, g, ADDR_W));
        assign match[g] = ((addr_i & MASK) == BASE);
    end

    // Priority select; scanning downward leaves the lowest matching index.
    always_comb begin
        logic     hit;
        slv_idx_t idx;
        hit = 1'b0;
        idx = IDX_NONE;
        if (instr_i) begin
            hit = 1'b1;
            idx = to_idx(DEF_SLV);
        end else begin
            for (int i = N_SLV - 1; i >= 0; i--) begin
                if (match[i]) begin
                    hit = 1'b1;
                    idx = to_idx(i);
                end
            end
            if (!hit && DEF_EN) begin
                hit = 1'b1;
                idx = to_idx(DEF_SLV);
            end
        end
        hit_o = hit;
        idx_o = idx;
    end

endmodule

// File: rtl/mmio_bus_decoder.sv
// Registered MMIO transaction engine between the CPU data port and N slaves.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for an armed request; decode and latch on issue
// ST_STROBE | one-cycle read/write strobe to the selected slave
// ST_WAIT   | waiting for the selected slave's ready, bounded by TIMEOUT
// ST_RESP   | one-cycle m_ready (and s_done on a real completion)
module mmio_bus_decoder
    import mmio_bus_pkg::*;
#(
    parameter int                      ADDR_W   = 16,
    parameter int                      DATA_W   = 16,
    parameter int                      N_SLV    = 4,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = '0,
    parameter int                      DEF_SLV  = N_SLV - 1,
    parameter bit                      DEF_EN   = 1'b1,
    parameter int                      TIMEOUT  = 255
) (
    input  logic                    cpu_clk,
    input  logic                    cpu_rst,
    input  logic [ADDR_W-1:0]       m_addr,
    input  logic [DATA_W-1:0]       m_wdata,
    input  logic                    m_read,
    input  logic                    m_write,
    input  logic                    m_instr,
    output logic [DATA_W-1:0]       m_rdata,
    output logic                    m_busy,
    output logic                    m_ready,
    output logic                    m_err,
    output logic [N_SLV-1:0]        s_read,
    output logic [N_SLV-1:0]        s_write,
    output logic [ADDR_W-1:0]       s_addr,
    output logic [DATA_W-1:0]       s_wdata,
    input  logic [N_SLV*DATA_W-1:0] s_rdata,
    input  logic [N_SLV-1:0]        s_ready,
    output logic [N_SLV-1:0]        s_done
);

    // A zero TIMEOUT disables the limit but still needs a one-bit counter.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e              state_q, state_d;
    logic                armed_q, armed_d;
    slv_idx_t            idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
    logic [DATA_W-1:0]   s_wdata_q, s_wdata_d;
    logic [DATA_W-1:0]   m_rdata_q, m_rdata_d;
    logic                m_busy_q, m_busy_d;
    logic                m_ready_q, m_ready_d;
    logic                m_err_q, m_err_d;
    logic [N_SLV-1:0]    s_read_q, s_read_d;
    logic [N_SLV-1:0]    s_write_q, s_write_d;
    logic [N_SLV-1:0]    s_done_q, s_done_d;

    logic                hit;
    slv_idx_t            hit_idx;
    logic                sel_ready;
    logic [DATA_W-1:0]   sel_rdata;
    logic                timed_out;

    function automatic logic [N_SLV-1:0] onehot(input slv_idx_t idx);
        logic [N_SLV-1:0] v;
        v = '0;
        for (int k = 0; k < N_SLV; k++) begin
            if (idx == to_idx(k)) v[k] = 1'b1;
        end
        return v;
    endfunction

    mmio_region_match #(
        .ADDR_W   (ADDR_W),
        .N_SLV    (N_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK),
        .DEF_SLV  (DEF_SLV),
        .DEF_EN   (DEF_EN)
    ) u_match (
        .addr_i  (m_addr),
        .instr_i (m_instr),
        .hit_o   (hit),
        .idx_o   (hit_idx)
    );

    // Only the latched slave's ready/rdata matter; every other slave is ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < N_SLV; k++) begin
            if (idx_q == to_idx(k)) begin
                sel_ready = s_ready[k];
                sel_rdata = s_rdata[k*DATA_W +: DATA_W];
            end
        end
    end

    assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

    // Next-state and next-output logic; all outputs are registered from these.
    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        m_rdata_d = m_rdata_q;
        m_err_d   = 1'b0;
        m_ready_d = 1'b0;
        s_read_d  = '0;
        s_write_d = '0;
        s_done_d  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (!m_read && !m_write) armed_d = 1'b1;
                if (armed_q && (m_read || m_write)) begin
                    s_addr_d  = m_addr;
                    s_wdata_d = m_wdata;
                    idx_d     = hit_idx;
                    if (hit) begin
                        state_d = ST_STROBE;
                        cnt_d   = '0;
                        if (m_write) s_write_d = onehot(hit_idx);
                        else         s_read_d  = onehot(hit_idx);
                    end else begin
                        state_d   = ST_RESP;
                        m_ready_d = 1'b1;
                        m_err_d   = 1'b1;
                        m_rdata_d = '0;
                    end
                end
            end
            ST_STROBE, ST_WAIT: begin
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                if (sel_ready) begin
                    state_d   = ST_RESP;
                    m_ready_d = 1'b1;
                    m_rdata_d = sel_rdata;
                    s_done_d  = onehot(idx_q);
                end else if ((state_q == ST_WAIT) && timed_out) begin
                    state_d   = ST_RESP;
                    m_ready_d = 1'b1;
                    m_err_d   = 1'b1;
                    m_rdata_d = '1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                armed_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
        m_busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset truncates any transaction in flight.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q   <= ST_IDLE;
            armed_q   <= 1'b1;
            idx_q     <= IDX_NONE;
            cnt_q     <= '0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            m_rdata_q <= '0;
            m_busy_q  <= 1'b0;
            m_ready_q <= 1'b0;
            m_err_q   <= 1'b0;
            s_read_q  <= '0;
            s_write_q <= '0;
            s_done_q  <= '0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            m_rdata_q <= m_rdata_d;
            m_busy_q  <= m_busy_d;
            m_ready_q <= m_ready_d;
            m_err_q   <= m_err_d;
            s_read_q  <= s_read_d;
            s_write_q <= s_write_d;
            s_done_q  <= s_done_d;
        end
    end

    assign m_rdata = m_rdata_q;
    assign m_busy  = m_busy_q;
    assign m_ready = m_ready_q;
    assign m_err   = m_err_q;
    assign s_read  = s_read_q;
    assign s_write = s_write_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;
    assign s_done  = s_done_q;

endmodule

// File: tb/tb_mmio_bus_decoder.sv
// Scoreboard bench for mmio_bus_decoder: four slaves with an overlapping
// region, unmapped traffic erroring (default routing off), TIMEOUT of 8.
module tb_mmio_bus_decoder;

    localparam int  ADDR_W  = 16;
    localparam int  DATA_W  = 16;
    localparam int  N_SLV   = 4;
    localparam int  DEF_SLV = 3;
    localparam bit  DEF_EN  = 1'b0;
    localparam int  TIMEOUT = 8;
    localparam int  NEVER   = 50;
    localparam logic [63:0] BASE_P = {16'h0000, 16'h2000, 16'h1000, 16'h0000};
    localparam logic [63:0] MASK_P = {16'h8000, 16'hF000, 16'hF000, 16'hFFFF};

    logic                    cpu_clk = 1'b0;
    logic                    cpu_rst = 1'b1;
    logic [ADDR_W-1:0]       m_addr  = '0;
    logic [DATA_W-1:0]       m_wdata = '0;
    logic                    m_read  = 1'b0;
    logic                    m_write = 1'b0;
    logic                    m_instr = 1'b0;
    logic [DATA_W-1:0]       m_rdata;
    logic                    m_busy, m_ready, m_err;
    logic [N_SLV-1:0]        s_read, s_write, s_done;
    logic [ADDR_W-1:0]       s_addr;
    logic [DATA_W-1:0]       s_wdata;
    logic [N_SLV*DATA_W-1:0] s_rdata = '0;
    logic [N_SLV-1:0]        s_ready = '0;

    mmio_bus_decoder #(
        .ADDR_W (ADDR_W), .DATA_W (DATA_W), .N_SLV (N_SLV),
        .SLV_BASE (BASE_P), .SLV_MASK (MASK_P),
        .DEF_SLV (DEF_SLV), .DEF_EN (DEF_EN), .TIMEOUT (TIMEOUT)
    ) dut (
        .cpu_clk (cpu_clk), .cpu_rst (cpu_rst),
        .m_addr (m_addr), .m_wdata (m_wdata), .m_read (m_read), .m_write (m_write),
        .m_instr (m_instr), .m_rdata (m_rdata), .m_busy (m_busy), .m_ready (m_ready),
        .m_err (m_err), .s_read (s_read), .s_write (s_write), .s_addr (s_addr),
        .s_wdata (s_wdata), .s_rdata (s_rdata), .s_ready (s_ready), .s_done (s_done)
    );

    always #5 cpu_clk = ~cpu_clk;

    int cyc = 0;
    always @(posedge cpu_clk) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          issue;
        int          lat;
        bit          err;
        bit          chk_rdata;
        logic [15:0] rdata;
        logic [3:0]  done;
        int          nstrobe;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_err    = 0;
    int          cur_delay = 0;
    logic [15:0] resp_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Address map as stated: instr -> default slave; lowest matching region; else unmapped.
    function automatic int model_decode(input logic [15:0] addr, input bit instr);
        logic [15:0] bases [4] = '{16'h0000, 16'h1000, 16'h2000, 16'h0000};
        logic [15:0] masks [4] = '{16'hFFFF, 16'hF000, 16'hF000, 16'h8000};
        if (instr) return DEF_SLV;
        for (int i = 0; i < 4; i++)
            if ((addr & masks[i]) == bases[i]) return i;
        return DEF_EN ? DEF_SLV : -1;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_m_busy"},  32'(m_busy), 0);
        check({tag, "_m_ready"}, 32'(m_ready), 0);
        check({tag, "_m_err"},   32'(m_err), 0);
        check({tag, "_m_rdata"}, 32'(m_rdata), 0);
        check({tag, "_s_read"},  32'(s_read), 0);
        check({tag, "_s_write"}, 32'(s_write), 0);
        check({tag, "_s_done"},  32'(s_done), 0);
        check({tag, "_s_addr"},  32'(s_addr), 0);
        check({tag, "_s_wdata"}, 32'(s_wdata), 0);
    endtask

    task automatic start_txn(input logic [15:0] addr, input bit wr, input bit both,
                             input bit instr, input logic [15:0] wdata,
                             input int delay, input logic [15:0] rdata);
        exp_t e;
        int   idx;
        bit   tmo;
        idx = model_decode(addr, instr);
        tmo = (idx >= 0) && (delay > TIMEOUT);
        cur_delay = delay;
        resp_data = rdata;
        @(posedge cpu_clk); #1;
        m_addr  = addr;
        m_wdata = wdata;
        m_instr = instr;
        m_write = wr;
        m_read  = !wr || both;
        e.idx = idx; e.wr = wr; e.addr = addr; e.wdata = wdata; e.issue = cyc;
        if (idx < 0) begin
            e.lat = 1; e.err = 1; e.chk_rdata = 1; e.rdata = 16'h0000; e.done = 4'h0; e.nstrobe = 0;
        end else if (tmo) begin
            e.lat = 2 + TIMEOUT; e.err = 1; e.chk_rdata = 1; e.rdata = 16'hFFFF; e.done = 4'h0; e.nstrobe = 1;
        end else begin
            e.lat = 2 + delay; e.err = 0; e.chk_rdata = !wr; e.rdata = rdata;
            e.done = 4'(1 << idx); e.nstrobe = 1;
        end
        sb.push_back(e);
    endtask

    task automatic finish_txn(input int hold);
        int n;
        n = 0;
        @(posedge cpu_clk); #1;
        m_addr  = 16'($urandom);
        m_wdata = 16'($urandom);
        m_instr = 1'($urandom);
        do begin
            @(negedge cpu_clk);
            n++;
        end while (!m_ready && n < 40);
        if (!m_ready) begin
            check("txn_complete", 32'(m_ready), 1);
            sb.delete();
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge cpu_clk);
            check("rearm_busy", 32'(m_busy), 0);
        end
        @(posedge cpu_clk); #1;
        m_read  = 1'b0;
        m_write = 1'b0;
    endtask

    task automatic do_txn(input logic [15:0] addr, input bit wr, input bit both, input bit instr,
                          input logic [15:0] wdata, input int delay, input logic [15:0] rdata,
                          input int hold);
        start_txn(addr, wr, both, instr, wdata, delay, rdata);
        finish_txn(hold);
    endtask

    // Slave responder: random ready/data noise everywhere except the strobed slave,
    // which answers after cur_delay cycles with resp_data.
    initial begin
        int active;
        int rem;
        active = -1;
        rem = 0;
        forever begin
            @(posedge cpu_clk); #1;
            if (cpu_rst) begin
                active = -1;
                s_ready = '0;
                continue;
            end
            s_ready = 4'($urandom);
            s_rdata = {$urandom, $urandom};
            if (m_ready) active = -1;
            for (int k = 0; k < N_SLV; k++) begin
                if (s_read[k] || s_write[k]) begin
                    active = k;
                    rem = cur_delay;
                end
            end
            if (active >= 0) begin
                if (rem == 0) begin
                    s_ready[active] = 1'b1;
                    s_rdata[active*DATA_W +: DATA_W] = resp_data;
                    active = -1;
                end else begin
                    s_ready[active] = 1'b0;
                    rem--;
                end
            end
        end
    end

    // Monitor: strobes and completions compared against the scoreboard head.
    initial begin
        int         nstb;
        exp_t       e;
        logic [3:0] stb;
        logic [3:0] vec;
        nstb = 0;
        forever begin
            @(negedge cpu_clk);
            if (cpu_rst) begin
                nstb = 0;
                continue;
            end
            stb = s_read | s_write;
            if (sb.size() == 0) begin
                check("idle_strobe", 32'(stb), 0);
                check("idle_ready", 32'(m_ready), 0);
            end else begin
                e = sb[0];
                vec = (e.idx >= 0) ? 4'(1 << e.idx) : 4'h0;
                if (stb != 4'h0) begin
                    nstb++;
                    check("strobe_cycle", 32'(cyc - e.issue), 1);
                    check("s_read",  32'(s_read),  e.wr ? 0 : 32'(vec));
                    check("s_write", 32'(s_write), e.wr ? 32'(vec) : 0);
                    check("s_addr",  32'(s_addr),  32'(e.addr));
                    if (e.wr) check("s_wdata", 32'(s_wdata), 32'(e.wdata));
                end
                if (m_ready) begin
                    void'(sb.pop_front());
                    check("latency", 32'(cyc - e.issue), 32'(e.lat));
                    check("m_err", 32'(m_err), 32'(e.err));
                    if (e.chk_rdata) check("m_rdata", 32'(m_rdata), 32'(e.rdata));
                    check("s_done", 32'(s_done), 32'(e.done));
                    check("strobe_count", 32'(nstb), 32'(e.nstrobe));
                    check("m_busy_resp", 32'(m_busy), 1);
                    nstb = 0;
                end
            end
            if (!m_ready) check("stray_done", 32'(s_done), 0);
        end
    end

    initial begin
        logic [15:0] a;
        int          d;
        #12;
        check_reset_vals("rst");
        @(posedge cpu_clk); #3 cpu_rst = 1'b0;

        // Overlap 0x0000 (slave0 and slave3): lowest index wins, immediate ready.
        do_txn(16'h0000, 0, 0, 0, 16'h0000, 0, 16'h00A5, 0);
        // Write to slave2 with a 3-cycle ready delay.
        do_txn(16'h2000, 1, 0, 0, 16'h1234, 3, 16'h0000, 0);
        // Instruction fetch at 0x0000 goes to the default slave.
        do_txn(16'h0000, 0, 0, 1, 16'h0000, 1, 16'h5A5A, 0);
        // Unmapped data read.
        do_txn(16'h9000, 0, 0, 0, 16'h0000, 0, 16'h1111, 0);
        // Slave never ready: timeout, then hold the request to exercise re-arm.
        do_txn(16'h1ABC, 0, 0, 0, 16'h0000, NEVER, 16'h0000, 4);
        // Ready on the last allowed cycle, then one cycle too late.
        do_txn(16'h3004, 0, 0, 0, 16'h0000, TIMEOUT, 16'hC0DE, 0);
        do_txn(16'h1004, 0, 0, 0, 16'h0000, TIMEOUT + 1, 16'hDEAD, 0);
        // Read and write both high: the write is issued.
        do_txn(16'h2F00, 1, 1, 0, 16'hABCD, 0, 16'h0000, 2);

        // Reset while waiting on a slave.
        start_txn(16'h1ABC, 0, 0, 0, 16'h0000, NEVER, 16'h0000);
        repeat (3) @(posedge cpu_clk);
        #3 cpu_rst = 1'b1;
        #1 check_reset_vals("midrst");
        m_read  = 1'b0;
        m_write = 1'b0;
        sb.delete();
        @(posedge cpu_clk); #3 cpu_rst = 1'b0;
        do_txn(16'h2100, 0, 0, 0, 16'h0000, 1, 16'hBEEF, 0);

        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 6))
                0:       a = 16'h0000;
                1:       a = 16'h1000 | 16'($urandom_range(0, 16'h0FFF));
                2:       a = 16'h2000 | 16'($urandom_range(0, 16'h0FFF));
                3:       a = 16'h3000 | 16'($urandom_range(0, 16'h0FFF));
                4:       a = 16'h4000 | 16'($urandom_range(0, 16'h3FFF));
                5:       a = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
                default: a = 16'($urandom);
            endcase
            d = $urandom_range(0, 10);
            if (d == 10) d = NEVER;
            do_txn(a, 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                   16'($urandom), d, 16'($urandom), $urandom_range(0, 2));
        end

        repeat (3) @(negedge cpu_clk);
        check("final_queue_empty", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
